irq_prio_ctrl: RTL and testbench

- Interrupt sequencer that sits directly after the 16-bit IRQ enable/mask peripheral and in front of the CPU core.
- Captures rising edges on the masked interrupt lines into a pending register.
- Selects one pending source by round-robin arbitration and presents its vector to the core with a req/ack handshake.
- Holds that source in service until the core signals end-of-interrupt (EOI), so only one interrupt is outstanding at a time.

---
 rtl/irq_pkg.sv | 34 +++
 rtl/irq_rr_arb.sv | 23 ++
 rtl/irq_prio_ctrl.sv | 92 +++++++++
 tb/tb_irq_prio_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types, defaults and the rotate-priority search used by the interrupt
// sequencer and any other round-robin arbiter in the codebase.
package irq_pkg;

  localparam int CIrqCntDef = 16;
  localparam int CVecWDef   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } irq_state_t;

  // Returns {found, index}. The scan runs from the highest offset down so the
  // last hit written is the one closest to ptr.
  function automatic logic [5:0] rr_find_first(input logic [31:0] pend,
                                               input int ptr,
                                               input int cnt);
    logic [5:0] res;
    logic [4:0] idx;
    int j;
    res = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i < cnt) begin
        j = ptr + i;
        if (j >= cnt) j = j - cnt;
        idx = 5'(j);
        if (pend[idx]) res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_rr_arb.sv
// Combinational round-robin arbiter: picks the first set bit of pend at or
// after ptr, wrapping at CIrqCnt.
module irq_rr_arb
  import irq_pkg::*;
#(
  parameter int CIrqCnt = CIrqCntDef,
  parameter int CVecW   = CVecWDef
) (
  input  logic [CIrqCnt-1:0] pend,
  input  logic [CVecW-1:0]   ptr,
  output logic               valid,
  output logic [CVecW-1:0]   idx
);

  logic [5:0] hit;

  always_comb begin
    hit   = rr_find_first(32'(pend), int'(ptr), CIrqCnt);
    valid = hit[5];
    idx   = CVecW'(hit[4:0]);
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Interrupt sequencer: captures rising edges into a pending register, grants one
// source round-robin and keeps it in service until the core signals EOI.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int CIrqCnt = CIrqCntDef,
  parameter int CVecW   = CVecWDef
) (
  input  logic               AClkH,
  input  logic               AResetH,
  input  logic               AClkHEn,
  input  logic [CIrqCnt-1:0] AIrqI,
  output logic               AIrqReq,
  output logic [CVecW-1:0]   AIrqVec,
  input  logic               AIrqAck,
  input  logic               AIrqEoi,
  output logic               AInServ,
  output logic [CIrqCnt-1:0] APend
);

  localparam logic [CVecW-1:0] CLastIdx = CVecW'(CIrqCnt - 1);

  irq_state_t         state, state_next;
  logic [CIrqCnt-1:0] pend, pend_next, prev, set, clr;
  logic [CVecW-1:0]   vec, vec_next, ptr, ptr_next, win_idx;
  logic               win_valid;

  assign set = AIrqI & ~prev;

  irq_rr_arb #(
    .CIrqCnt(CIrqCnt),
    .CVecW  (CVecW)
  ) u_arb (
    .pend (pend),
    .ptr  (ptr),
    .valid(win_valid),
    .idx  (win_idx)
  );

  // A fresh edge on the source being acknowledged wins over its clear, so a
  // re-trigger during the handshake is never lost.
  always_comb begin
    state_next = state;
    vec_next   = vec;
    ptr_next   = ptr;
    clr        = '0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          vec_next   = win_idx;
          ptr_next   = (win_idx == CLastIdx) ? '0 : win_idx + 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (AIrqAck) begin
          clr        = CIrqCnt'(1) << vec;
          state_next = SERV;
        end
      end
      SERV: begin
        if (AIrqEoi) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    pend_next = (pend & ~clr) | set;
  end

  always_ff @(posedge AClkH) begin
    if (AClkHEn) begin
      if (AResetH) begin
        state <= IDLE;
        pend  <= '0;
        prev  <= '0;
        ptr   <= '0;
        vec   <= '0;
      end else begin
        state <= state_next;
        pend  <= pend_next;
        prev  <= AIrqI;
        ptr   <= ptr_next;
        vec   <= vec_next;
      end
    end
  end

  assign AIrqReq = (state == REQ);
  assign AInServ = (state == SERV);
  assign AIrqVec = vec;
  assign APend   = pend;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Self-checking bench for irq_prio_ctrl: table-driven vectors plus hand-written
// multi-cycle sequences, all checked through an expected-result queue.
module tb_irq_prio_ctrl;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  logic        clk = 1'b0;
  logic        rst, en, ack, eoi;
  logic [15:0] irq;
  logic        req, serv;
  logic [3:0]  vec;
  logic [15:0] pend;

  always #5 clk = ~clk;

  irq_prio_ctrl dut (
    .AClkH  (clk),
    .AResetH(rst),
    .AClkHEn(en),
    .AIrqI  (irq),
    .AIrqReq(req),
    .AIrqVec(vec),
    .AIrqAck(ack),
    .AIrqEoi(eoi),
    .AInServ(serv),
    .APend  (pend)
  );

  typedef struct packed {
    logic        req;
    logic [3:0]  vec;
    logic        serv;
    logic [15:0] pend;
  } obs_t;

  typedef struct {
    string       tag;
    logic [15:0] irq;
    logic        ack;
    logic        eoi;
    logic        en;
    logic        rst;
    obs_t        exp;
  } vector_t;

  vector_t table_q[$];
  obs_t    exp_q[$];
  string   tag_q[$];
  int      compared   = 0;
  int      mismatched = 0;
  int      req_rises;
  logic    req_last;

  function automatic vector_t mk(string tag, logic [15:0] irq_v, logic ack_v,
                                 logic eoi_v, logic en_v, logic rst_v,
                                 logic req_v, logic [3:0] vec_v, logic serv_v,
                                 logic [15:0] pend_v);
    vector_t v;
    v.tag      = tag;
    v.irq      = irq_v;
    v.ack      = ack_v;
    v.eoi      = eoi_v;
    v.en       = en_v;
    v.rst      = rst_v;
    v.exp.req  = req_v;
    v.exp.vec  = vec_v;
    v.exp.serv = serv_v;
    v.exp.pend = pend_v;
    return v;
  endfunction

  // Drives one cycle of inputs, queues the expected post-edge outputs, then
  // samples just after the active edge.
  task automatic applyStimulus(input vector_t v);
    irq = v.irq;
    ack = v.ack;
    eoi = v.eoi;
    en  = v.en;
    rst = v.rst;
    exp_q.push_back(v.exp);
    tag_q.push_back(v.tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    obs_t  act, want;
    string tag;
    act.req  = req;
    act.vec  = vec;
    act.serv = serv;
    act.pend = pend;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard: no expected entry, got req=%0b vec=%0d serv=%0b pend=%04h",
               act.req, act.vec, act.serv, act.pend);
      return;
    end
    want = exp_q.pop_front();
    tag  = tag_q.pop_front();
    if (act !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got req=%0b vec=%0d serv=%0b pend=%04h, want req=%0b vec=%0d serv=%0b pend=%04h",
               tag, act.req, act.vec, act.serv, act.pend,
               want.req, want.vec, want.serv, want.pend);
    end
  endtask

  task automatic doReset();
    applyStimulus(mk("reset", 16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));
  endtask

  initial begin
    rst = HI; en = HI; ack = LO; eoi = LO; irq = '0;

    // Single source: capture, request, ack, EOI, ack ignored while idle.
    table_q.push_back(mk("reset",      16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));
    table_q.push_back(mk("reset",      16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));
    table_q.push_back(mk("t1_edge",    16'h0008, LO, LO, HI, LO, LO, 4'd0, LO, 16'h0008));
    table_q.push_back(mk("t1_req",     16'h0008, LO, LO, HI, LO, HI, 4'd3, LO, 16'h0008));
    table_q.push_back(mk("t1_ack",     16'h0008, HI, LO, HI, LO, LO, 4'd3, HI, 16'h0000));
    table_q.push_back(mk("t1_serv",    16'h0000, LO, LO, HI, LO, LO, 4'd3, HI, 16'h0000));
    table_q.push_back(mk("t1_eoi",     16'h0000, LO, HI, HI, LO, LO, 4'd3, LO, 16'h0000));
    table_q.push_back(mk("t1_ackidle", 16'h0000, HI, LO, HI, LO, LO, 4'd3, LO, 16'h0000));
    table_q.push_back(mk("t1_idle",    16'h0000, LO, LO, HI, LO, LO, 4'd3, LO, 16'h0000));
    // Two simultaneous edges, then round-robin order flips once ptr has moved.
    table_q.push_back(mk("reset",      16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));
    table_q.push_back(mk("t2_edge",    16'h0021, LO, LO, HI, LO, LO, 4'd0, LO, 16'h0021));
    table_q.push_back(mk("t2_req0",    16'h0021, LO, LO, HI, LO, HI, 4'd0, LO, 16'h0021));
    table_q.push_back(mk("t2_ack0",    16'h0000, HI, LO, HI, LO, LO, 4'd0, HI, 16'h0020));
    table_q.push_back(mk("t2_reedge",  16'h0021, LO, HI, HI, LO, LO, 4'd0, LO, 16'h0021));
    table_q.push_back(mk("t2_req5",    16'h0021, LO, LO, HI, LO, HI, 4'd5, LO, 16'h0021));
    table_q.push_back(mk("t2_ack5",    16'h0021, HI, LO, HI, LO, LO, 4'd5, HI, 16'h0001));
    table_q.push_back(mk("t2_eoi5",    16'h0021, LO, HI, HI, LO, LO, 4'd5, LO, 16'h0001));
    table_q.push_back(mk("t2_req0b",   16'h0021, LO, LO, HI, LO, HI, 4'd0, LO, 16'h0001));
    table_q.push_back(mk("t2_ack0b",   16'h0021, HI, LO, HI, LO, LO, 4'd0, HI, 16'h0000));
    table_q.push_back(mk("t2_eoi0b",   16'h0000, LO, HI, HI, LO, LO, 4'd0, LO, 16'h0000));
    // Vector held stable in REQ while another source pends; EOI ignored in REQ.
    table_q.push_back(mk("reset",      16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));
    table_q.push_back(mk("t4_edge",    16'h0010, LO, LO, HI, LO, LO, 4'd0, LO, 16'h0010));
    table_q.push_back(mk("t4_req4",    16'h0010, LO, LO, HI, LO, HI, 4'd4, LO, 16'h0010));
    table_q.push_back(mk("t4_raise1",  16'h0012, LO, LO, HI, LO, HI, 4'd4, LO, 16'h0012));
    table_q.push_back(mk("t4_eoireq",  16'h0012, LO, HI, HI, LO, HI, 4'd4, LO, 16'h0012));
    table_q.push_back(mk("t4_ack4",    16'h0012, HI, LO, HI, LO, LO, 4'd4, HI, 16'h0002));
    table_q.push_back(mk("t4_eoi4",    16'h0012, LO, HI, HI, LO, LO, 4'd4, LO, 16'h0002));
    table_q.push_back(mk("t4_req1",    16'h0000, LO, LO, HI, LO, HI, 4'd1, LO, 16'h0002));
    table_q.push_back(mk("t4_ack1",    16'h0000, HI, LO, HI, LO, LO, 4'd1, HI, 16'h0000));
    table_q.push_back(mk("t4_eoi1",    16'h0000, LO, HI, HI, LO, LO, 4'd1, LO, 16'h0000));
    // Reset while in service with two sources pending.
    table_q.push_back(mk("reset",      16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));
    table_q.push_back(mk("t6_edge",    16'h0080, LO, LO, HI, LO, LO, 4'd0, LO, 16'h0080));
    table_q.push_back(mk("t6_req7",    16'h0080, LO, LO, HI, LO, HI, 4'd7, LO, 16'h0080));
    table_q.push_back(mk("t6_serv",    16'h0380, HI, LO, HI, LO, LO, 4'd7, HI, 16'h0300));
    table_q.push_back(mk("t6_rstserv", 16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));
    table_q.push_back(mk("t6_after",   16'h0000, LO, LO, HI, LO, LO, 4'd0, LO, 16'h0000));
    // Pointer wrap from the top source, and set beating clear on the acked bit.
    table_q.push_back(mk("t7_edge15",  16'h8000, LO, LO, HI, LO, LO, 4'd0, LO, 16'h8000));
    table_q.push_back(mk("t7_req15",   16'h8000, LO, LO, HI, LO, HI, 4'd15, LO, 16'h8000));
    table_q.push_back(mk("t7_ack15",   16'h8001, HI, LO, HI, LO, LO, 4'd15, HI, 16'h0001));
    table_q.push_back(mk("t7_eoi15",   16'h0000, LO, HI, HI, LO, LO, 4'd15, LO, 16'h0001));
    table_q.push_back(mk("t7_wrap0",   16'h0000, LO, LO, HI, LO, HI, 4'd0, LO, 16'h0001));
    table_q.push_back(mk("t7_setclr",  16'h0001, HI, LO, HI, LO, LO, 4'd0, HI, 16'h0001));
    table_q.push_back(mk("t7_eoi0",    16'h0001, LO, HI, HI, LO, LO, 4'd0, LO, 16'h0001));
    table_q.push_back(mk("t7_rereq0",  16'h0001, LO, LO, HI, LO, HI, 4'd0, LO, 16'h0001));
    table_q.push_back(mk("t7_ack0",    16'h0000, HI, LO, HI, LO, LO, 4'd0, HI, 16'h0000));
    table_q.push_back(mk("t7_eoi0b",   16'h0000, LO, HI, HI, LO, LO, 4'd0, LO, 16'h0000));

    foreach (table_q[k]) applyStimulus(table_q[k]);

    // Level-held input must produce exactly one request.
    doReset();
    req_rises = 0;
    req_last  = LO;
    for (int c = 1; c <= 20; c++) begin
      logic        r, s;
      logic [15:0] p;
      r = (c == 2);
      s = (c == 3);
      p = (c <= 2) ? 16'h0004 : 16'h0000;
      applyStimulus(mk("t3_hold", 16'h0004, logic'(c == 3), logic'(c == 4), HI, LO,
                       r, (c == 1) ? 4'd0 : 4'd2, s, p));
      if (req && !req_last) req_rises++;
      req_last = req;
    end
    compared++;
    if (req_rises != 1) begin
      mismatched++;
      $display("[TB] FAIL t3_reqcount: got %0d requests, want 1", req_rises);
    end
    applyStimulus(mk("t3_drop",    16'h0000, LO, LO, HI, LO, LO, 4'd2, LO, 16'h0000));
    applyStimulus(mk("t3_raise",   16'h0004, LO, LO, HI, LO, LO, 4'd2, LO, 16'h0004));
    applyStimulus(mk("t3_req2",    16'h0004, LO, LO, HI, LO, HI, 4'd2, LO, 16'h0004));
    applyStimulus(mk("t3_ack2",    16'h0000, HI, LO, HI, LO, LO, 4'd2, HI, 16'h0000));
    applyStimulus(mk("t3_reserv",  16'h0004, LO, LO, HI, LO, LO, 4'd2, HI, 16'h0004));
    applyStimulus(mk("t3_eoi2",    16'h0004, LO, HI, HI, LO, LO, 4'd2, LO, 16'h0004));
    applyStimulus(mk("t3_req2b",   16'h0004, LO, LO, HI, LO, HI, 4'd2, LO, 16'h0004));
    applyStimulus(mk("t3_ack2b",   16'h0000, HI, LO, HI, LO, LO, 4'd2, HI, 16'h0000));
    applyStimulus(mk("t3_eoi2b",   16'h0000, LO, HI, HI, LO, LO, 4'd2, LO, 16'h0000));

    // Clock enable low freezes everything, including ack and reset.
    doReset();
    applyStimulus(mk("t5_edge",    16'h0040, LO, LO, HI, LO, LO, 4'd0, LO, 16'h0040));
    applyStimulus(mk("t5_req6",    16'h0040, LO, LO, HI, LO, HI, 4'd6, LO, 16'h0040));
    for (int c = 0; c < 5; c++)
      applyStimulus(mk("t5_frozen", 16'h0000, HI, LO, LO, LO, HI, 4'd6, LO, 16'h0040));
    applyStimulus(mk("t5_ack6",    16'h0000, HI, LO, HI, LO, LO, 4'd6, HI, 16'h0000));
    applyStimulus(mk("t5_eoi6",    16'h0000, LO, HI, HI, LO, LO, 4'd6, LO, 16'h0000));
    applyStimulus(mk("t5_rstgated", 16'h0000, LO, LO, LO, HI, LO, 4'd6, LO, 16'h0000));
    applyStimulus(mk("t5_rst",     16'h0000, LO, LO, HI, HI, LO, 4'd0, LO, 16'h0000));

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: %0d expected entries left over", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
